// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcodes and issue-stage FSM encoding
package alu_pkg;

  localparam int OPCODE_W = 3;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SLL = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_SRL = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - load, command, ALU and debug signals of the issue stage
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 8
);
  localparam int AW = $clog2(NREG);

  logic             ld_valid;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [AW-1:0]    cmd_src_a;
  logic [AW-1:0]    cmd_src_b;
  logic [AW-1:0]    cmd_dst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic             alu_en;
  logic [WIDTH-1:0] alu_result;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output ld_valid, ld_addr, ld_data, cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b,
           cmd_dst, alu_result, rd_addr,
    input  cmd_ready, alu_a, alu_b, alu_opcode, alu_en, done, result, rd_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b,
           cmd_dst, alu_result, rd_addr,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_en, done, result, rd_data
  );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - operand register file, one write port, three async read ports
module alu_regfile #(
  parameter int WIDTH = 32,
  parameter int NREG  = 8,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    ra_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [AW-1:0]    rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = rf_q[ra_addr_i];
  assign rb_data_o = rf_q[rb_addr_i];
  assign rd_data_o = rf_q[rd_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one register-file command to the ALU and writes the result back
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NREG  = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  state_e               state_q;
  logic [WIDTH-1:0]     alu_a_q;
  logic [WIDTH-1:0]     alu_b_q;
  logic [WIDTH-1:0]     result_q;
  logic [OPCODE_W-1:0]  opcode_q;
  logic                 en_q;
  logic                 done_q;
  logic [AW-1:0]        dst_q;

  logic                 idle;
  logic                 cmd_ready;
  logic                 cmd_acc;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [WIDTH-1:0]     rf_wdata;
  logic [WIDTH-1:0]     src_a_data;
  logic [WIDTH-1:0]     src_b_data;

  assign idle      = (state_q == ST_IDLE);
  assign cmd_ready = idle && !bus.ld_valid;
  assign cmd_acc   = cmd_ready && bus.cmd_valid;

  // Loads only land in IDLE; writeback owns the port on the edge leaving EXEC.
  assign rf_we    = (idle && bus.ld_valid) || (state_q == ST_EXEC);
  assign rf_waddr = (state_q == ST_EXEC) ? dst_q : bus.ld_addr;
  assign rf_wdata = (state_q == ST_EXEC) ? bus.alu_result : bus.ld_data;

  alu_regfile #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .ra_addr_i (bus.cmd_src_a),
    .ra_data_o (src_a_data),
    .rb_addr_i (bus.cmd_src_b),
    .rb_data_o (src_b_data),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (bus.rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      opcode_q <= OP_ADD;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      dst_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            state_q  <= ST_EXEC;
            alu_a_q  <= src_a_data;
            alu_b_q  <= src_b_data;
            opcode_q <= bus.cmd_opcode;
            dst_q    <= bus.cmd_dst;
            en_q     <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_q  <= ST_WB;
          result_q <= bus.alu_result;
          en_q     <= 1'b0;
          done_q   <= 1'b1;
        end
        ST_WB: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_en     = en_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and randomized checks of alu_issue_ctrl against a stub ALU
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  assign bus.alu_result = bus.alu_en ? bus.alu_a + bus.alu_b : '0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a command is a timeline keyed on the edge it was accepted at.
  logic [31:0]   m_rf [NREG];
  logic [31:0]   m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]    m_op = '0;
  logic [AW-1:0] m_dst = '0;
  int            cyc = 0;
  int            acc = -100;
  int            m_p;
  int            c_p;
  bit            m_acc_now = 1'b0;

  initial foreach (m_rf[i]) m_rf[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_a = '0; m_b = '0; m_res = '0; m_op = '0;
      acc = cyc - 100;
      m_acc_now = 1'b0;
    end else begin
      cyc++;
      m_p = cyc - acc;
      m_acc_now = 1'b0;
      if (m_p == 1) begin
        m_res = m_a + m_b;
        m_rf[m_dst] = m_res;
      end else if (m_p >= 3) begin
        if (bus.ld_valid) begin
          m_rf[bus.ld_addr] = bus.ld_data;
        end else if (bus.cmd_valid) begin
          m_a = m_rf[bus.cmd_src_a];
          m_b = m_rf[bus.cmd_src_b];
          m_op = bus.cmd_opcode;
          m_dst = bus.cmd_dst;
          acc = cyc;
          m_acc_now = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    c_p = cyc - acc;
    chk("m_alu_en", {31'b0, bus.alu_en}, {31'b0, c_p == 0});
    chk("m_done", {31'b0, bus.done}, {31'b0, c_p == 1});
    chk("m_cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, (c_p >= 2) && !bus.ld_valid});
    chk("m_alu_a", bus.alu_a, m_a);
    chk("m_alu_b", bus.alu_b, m_b);
    chk("m_alu_opcode", {29'b0, bus.alu_opcode}, {29'b0, m_op});
    chk("m_result", bus.result, m_res);
    chk("m_rd_data", bus.rd_data, m_rf[bus.rd_addr]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_src_a  = a;
    bus.cmd_src_b  = b;
    bus.cmd_dst    = d;
  endtask

  task automatic set_ld(input logic [AW-1:0] addr, input logic [31:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
  endtask

  initial begin
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_src_a = '0;
    bus.cmd_src_b = '0; bus.cmd_dst = '0; bus.rd_addr = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < NREG; i++) begin
      bus.rd_addr = AW'(i);
      #1 chk("rst_rd_data", bus.rd_data, 32'd0);
    end
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_alu_en", {31'b0, bus.alu_en}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    tick();
    rst_n = 1'b1;

    // r1=4, r2=2, r3 = r1 + r2
    set_ld(3'd1, 32'd4);
    tick();
    set_ld(3'd2, 32'd2);
    tick();
    bus.ld_valid = 1'b0;
    set_cmd(3'b000, 3'd1, 3'd2, 3'd3);
    tick();
    bus.cmd_valid = 1'b0;
    bus.rd_addr = 3'd3;
    @(negedge clk);
    chk("basic_alu_a", bus.alu_a, 32'd4);
    chk("basic_alu_b", bus.alu_b, 32'd2);
    chk("basic_en_hi", {31'b0, bus.alu_en}, 32'd1);
    chk("basic_ready_lo", {31'b0, bus.cmd_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("basic_en_lo", {31'b0, bus.alu_en}, 32'd0);
    chk("basic_done", {31'b0, bus.done}, 32'd1);
    chk("basic_result", bus.result, 32'd6);
    chk("basic_rd_r3", bus.rd_data, 32'd6);
    tick();
    @(negedge clk);
    chk("basic_done_lo", {31'b0, bus.done}, 32'd0);
    chk("basic_ready_hi", {31'b0, bus.cmd_ready}, 32'd1);

    // load and command together: load wins, command uses the new r4
    tick();
    set_ld(3'd4, 32'd10);
    set_cmd(3'b010, 3'd4, 3'd1, 3'd6);
    @(negedge clk);
    chk("prio_ready_lo", {31'b0, bus.cmd_ready}, 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("prio_no_accept", {31'b0, bus.alu_en}, 32'd0);
    chk("prio_ready_hi", {31'b0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("prio_alu_a", bus.alu_a, 32'd10);
    chk("prio_alu_b", bus.alu_b, 32'd4);
    chk("prio_opcode", {29'b0, bus.alu_opcode}, 32'd2);
    tick();
    bus.rd_addr = 3'd6;
    @(negedge clk);
    chk("prio_result", bus.result, 32'd14);
    chk("prio_rd_r6", bus.rd_data, 32'd14);
    tick();

    // in-place update of r5
    set_ld(3'd5, 32'd7);
    tick();
    bus.ld_valid = 1'b0;
    set_cmd(3'b001, 3'd5, 3'd5, 3'd5);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("inplace_alu_a", bus.alu_a, 32'd7);
    chk("inplace_alu_b", bus.alu_b, 32'd7);
    tick();
    tick();
    bus.rd_addr = 3'd5;
    @(negedge clk);
    chk("inplace_rd_r5", bus.rd_data, 32'd14);

    // back-to-back with cmd_valid held: r7 = r1 + r3, then r0 = r7 + r7
    set_cmd(3'b000, 3'd1, 3'd3, 3'd7);
    tick();
    set_cmd(3'b000, 3'd7, 3'd7, 3'd0);
    @(negedge clk);
    chk("b2b_en1", {31'b0, bus.alu_en}, 32'd1);
    chk("b2b_ready_exec", {31'b0, bus.cmd_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("b2b_done1", {31'b0, bus.done}, 32'd1);
    chk("b2b_ready_wb", {31'b0, bus.cmd_ready}, 32'd0);
    chk("b2b_result1", bus.result, 32'd10);
    tick();
    @(negedge clk);
    chk("b2b_gap_en", {31'b0, bus.alu_en}, 32'd0);
    chk("b2b_gap_ready", {31'b0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_en2", {31'b0, bus.alu_en}, 32'd1);
    chk("b2b_alu_a2", bus.alu_a, 32'd10);
    tick();
    @(negedge clk);
    chk("b2b_done2", {31'b0, bus.done}, 32'd1);
    chk("b2b_result2", bus.result, 32'd20);
    tick();

    // reset dropped in EXEC aborts the writeback
    set_cmd(3'b000, 3'd1, 3'd2, 3'd1);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en", {31'b0, bus.alu_en}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_ready", {31'b0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < NREG; i++) begin
      bus.rd_addr = AW'(i);
      #0.5 chk("abort_rd_data", bus.rd_data, 32'd0);
    end
    tick();
    rst_n = 1'b1;
    bus.rd_addr = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, bus.done}, 32'd0);
      chk("abort_no_wb", bus.rd_data, 32'd0);
      tick();
    end

    // randomized traffic against the reference timeline
    for (int n = 0; n < 600; n++) begin
      if (bus.cmd_valid && m_acc_now) bus.cmd_valid = 1'b0;
      if (!bus.cmd_valid && ($urandom_range(0, 1) == 1)) begin
        set_cmd(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREG - 1)),
                AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
      end
      bus.ld_valid = ((cyc - acc) >= 2) && ($urandom_range(0, 3) == 0);
      bus.ld_addr  = AW'($urandom_range(0, NREG - 1));
      bus.ld_data  = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 15));
      bus.rd_addr  = AW'($urandom_range(0, NREG - 1));
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
